// File: rtl/spi_pkg.sv
// Shared constants and helpers for the SPI baud-rate generator.
package spi_pkg;

  localparam int DEF_DIV_W = 12;
  localparam int DEF_CNT_W = 11;

  localparam logic [1:0] SPI_MODE_RUN  = 2'b00;
  localparam logic [1:0] SPI_MODE_WAIT = 2'b01;
  localparam logic [1:0] SPI_MODE_STOP = 2'b10;

  // Full SCLK period in PCLKs: (sppr+1) << (spr+1). The shift amount is
  // widened so that spr=7 does not wrap to a shift of 0.
  function automatic logic [DEF_DIV_W-1:0] calc_divisor(input logic [2:0] sppr,
                                                        input logic [2:0] spr);
    logic [DEF_DIV_W-1:0] base;
    logic [3:0]           sh;
    base = DEF_DIV_W'({1'b0, sppr}) + DEF_DIV_W'(1);
    sh   = {1'b0, spr} + 4'd1;
    return base << sh;
  endfunction

  // Half SCLK period in PCLKs: (sppr+1) << spr, range 1..1024.
  function automatic logic [DEF_CNT_W-1:0] calc_half(input logic [2:0] sppr,
                                                     input logic [2:0] spr);
    logic [DEF_CNT_W-1:0] base;
    base = DEF_CNT_W'({1'b0, sppr}) + DEF_CNT_W'(1);
    return base << spr;
  endfunction

endpackage

// File: rtl/spi_baud_counter.sv
// Half-period counter: counts up from 0 to half-1, then wraps.
// term marks the last count of a half period; term_m1 marks the count
// before it (or the last count itself when half is 1).
module spi_baud_counter #(
  parameter int CNT_W = 11
) (
  input  logic             PCLK,
  input  logic             clr,
  input  logic [CNT_W-1:0] half,
  output logic [CNT_W-1:0] cnt,
  output logic             term,
  output logic             term_m1
);

  // Count register; clr covers both reset and the idle state.
  always_ff @(posedge PCLK) begin
    if (clr) begin
      cnt <= '0;
    end else if (term) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Terminal and terminal-minus-one decode against the loaded half period.
  always_comb begin
    term    = (cnt == (half - CNT_W'(1)));
    term_m1 = term;
    if (half > CNT_W'(1)) begin
      term_m1 = (cnt == (half - CNT_W'(2)));
    end
  end

endmodule

// File: rtl/spi_baud_generator.sv
// SPI baud-rate generator: divides PCLK into SCLK and produces the
// edge-anticipation strobes used by the shift register.
module spi_baud_generator
  import spi_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [1:0]       spi_mode,
  input  logic             spiswai,
  input  logic [2:0]       sppr,
  input  logic [2:0]       spr,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             ss,
  output logic             sclk,
  output logic             flag_low,
  output logic             flag_high,
  output logic             flags_low,
  output logic             flags_high,
  output logic [DIV_W-1:0] baudratedivisor,
  output logic             cpha_q
);

  logic             active;
  logic             active_q;
  logic             run;
  logic [2:0]       sppr_l;
  logic [2:0]       spr_l;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt;
  logic             term;
  logic             term_m1;

  // Clock runs only while selected and the mode allows it.
  always_comb begin
    active = !ss && ((spi_mode == SPI_MODE_RUN) ||
                     ((spi_mode == SPI_MODE_WAIT) && !spiswai));
    run    = active && PRESETn;
    half   = CNT_W'(calc_half(sppr_l, spr_l));
  end

  // Divisor latch: tracks the inputs while idle and on the first active
  // cycle, then freezes for the rest of the transfer.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      active_q <= 1'b0;
      sppr_l   <= 3'd0;
      spr_l    <= 3'd0;
    end else begin
      active_q <= active;
      if (!active_q) begin
        sppr_l <= sppr;
        spr_l  <= spr;
      end
    end
  end

  // SCLK register: parks at cpol when idle, toggles at each half-period end.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      sclk <= cpol;
    end else if (!active) begin
      sclk <= cpol;
    end else if (term) begin
      sclk <= ~sclk;
    end
  end

  // cpha is only retimed here; the shift register interprets it.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      cpha_q <= 1'b0;
    end else begin
      cpha_q <= cpha;
    end
  end

  spi_baud_counter #(.CNT_W(CNT_W)) u_counter (
    .PCLK    (PCLK),
    .clr     (!run),
    .half    (half),
    .cnt     (cnt),
    .term    (term),
    .term_m1 (term_m1)
  );

  // Strobes refer to the actual SCLK level, not to cpol.
  always_comb begin
    flag_low        = run && !sclk && term;
    flag_high       = run &&  sclk && term;
    flags_low       = run && !sclk && term_m1;
    flags_high      = run &&  sclk && term_m1;
    baudratedivisor = DIV_W'(calc_divisor(sppr_l, spr_l));
  end

endmodule

// File: doc/spi_baud_generator.md
Name: spi_baud_generator

Overview:
- Upstream neighbour of the SPI shift register. Divides PCLK to produce the serial clock `sclk`.
- Also produces the single-cycle edge-anticipation strobes `flag_low`, `flag_high`, `flags_low` and `flags_high`. The shift register uses these to launch MOSI bits and sample MISO bits.
- Runs only while the slave is selected and the SPI mode permits. Otherwise it parks `sclk` at the CPOL idle level.

Parameters:
- DIV_W, 12, width of the `baudratedivisor` output (the maximum divisor is 2048).
- CNT_W, 11, width of the internal half-period counter.

Ports:
- PCLK  input  1  system clock; all logic is on the rising edge.
- PRESETn  input  1  reset; synchronous, active-low.
- spi_mode  input  2  00 = RUN, 01 = WAIT, 10/11 = STOP.
- spiswai  input  1  1 = stop SPI clocks in WAIT mode.
- sppr  input  3  baud prescaler select.
- spr  input  3  baud rate select.
- cpol  input  1  clock polarity; `sclk` idle level.
- cpha  input  1  clock phase; passed through to the registered `cpha_q` output.
- ss  input  1  slave select, active-low.
- sclk  output  1  serial clock, registered.
- flag_low  output  1  pulse: `sclk` is 0 and toggles (rises) on the next PCLK edge.
- flag_high  output  1  pulse: `sclk` is 1 and toggles (falls) on the next PCLK edge.
- flags_low  output  1  pulse one PCLK earlier than `flag_low`.
- flags_high  output  1  pulse one PCLK earlier than `flag_high`.
- baudratedivisor  output  DIV_W  current divisor = (sppr+1) << (spr+1).
- cpha_q  output  1  `cpha` registered once per PCLK.

Behaviour:
- **Reset** (PRESETn=0 at a PCLK edge):
  - `sclk` = `cpol` as sampled that cycle.
  - All flags = 0.
  - Counter = 0.
  - Latched sppr/spr = 0, so `baudratedivisor` = 2.
  - `cpha_q` = 0.
- **active** = !ss && (spi_mode==RUN || (spi_mode==WAIT && !spiswai)).
- **Divisor latching:**
  - On the idle-to-active transition (first active cycle), sppr/spr are latched. `baudratedivisor` reflects the latched values.
  - Changes to sppr/spr while active are ignored until the next idle-to-active transition.
- **half** = (sppr_l+1) << spr_l. Range 1..1024.
- **IDLE** (not active):
  - Counter held at 0.
  - `sclk` follows `cpol`, registered, so it has one PCLK latency.
  - All flags held at 0.
  - While idle, sppr/spr are continuously latched.
- **RUN** (active):
  - Counter increments each PCLK.
  - When counter == half-1: counter returns to 0 and `sclk` toggles on the same edge.
  - The first toggle occurs `half` PCLKs after entering active.
- **Flags** are combinational from the registered counter and `sclk`; each is a 1-PCLK pulse per half-period:
  - `flag_low` = active && sclk==0 && cnt==half-1.
  - `flag_high` = active && sclk==1 && cnt==half-1.
  - `flags_low` = active && sclk==0 && cnt==half-2, for half>=2.
  - `flags_high` = active && sclk==1 && cnt==half-2, for half>=2.
  - For half==1, `flags_low`/`flags_high` equal `flag_low`/`flag_high`.
- **Polarity independence:** flags refer to actual `sclk` level, independent of `cpol`. The shift register combines them with `cpol`/`cpha`.
- **Deactivation mid-transfer** (ss→1 or mode change): on the next PCLK edge, counter=0, flags=0 and `sclk`=`cpol`. No partial period is completed.
- **Reactivation:** starts a fresh period from counter 0 with newly latched sppr/spr.
- **Reset mid-transfer:** behaves as reset; synchronous reset has priority over all other updates.
- **cpol change while active:** has no effect on `sclk` until idle.

Decomposition:
- **spi_pkg:**
  - SPI_MODE_RUN=2'b00, SPI_MODE_WAIT=2'b01, SPI_MODE_STOP=2'b10.
  - DIV_W and CNT_W defaults.
  - Function calc_divisor(sppr, spr) returning DIV_W bits.
- **spi_baud_counter** sub-module: half-period counter with sync clear, load of `half`, and terminal/terminal-1 outputs.
- The top level holds the `sclk` register, the sppr/spr latch, active decode and flag generation.

Test Plan:
1. **Reset and idle.**
   - Stimulus: PRESETn=0 for 2 cycles with cpol=1, then ss=1.
   - Required: sclk=1, all flags=0, baudratedivisor=2, cpha_q=0.
2. **Divisor 8.**
   - Stimulus: sppr=1, spr=1, ss=0, mode RUN, cpol=0.
   - Required: baudratedivisor=8. sclk period = 8 PCLK (4 high/4 low). flags_low 1 cycle before flag_low. flag_low exactly 1 cycle before each sclk rise. No overlap between low and high flags.
3. **Minimum divisor.**
   - Stimulus: sppr=0, spr=0.
   - Required: sclk toggles every PCLK. flag_low/flag_high alternate every cycle. flags_* equal flag_*.
4. **Maximum divisor.**
   - Stimulus: sppr=7, spr=7.
   - Required: baudratedivisor=2048. First sclk toggle 1024 PCLKs after ss falls. Counter does not overflow.
5. **WAIT and ss deassert.**
   - Stimulus: mode WAIT with spiswai=1.
   - Required: sclk parked at cpol, no flags.
   - Stimulus: then spiswai=0.
   - Required: clock runs.
   - Stimulus: ss=1 mid-period.
   - Required: next cycle sclk=cpol, counter restarts on reselect.
6. **Mid-transfer sppr change ignored.**
   - Stimulus: change sppr 1→3 while active.
   - Required: period stays 8. After ss 1→0, period becomes 16 and baudratedivisor=16.
